cpu_mdu_seq: RTL

Execute-stage sequencer that sits directly upstream and downstream of cpu_mdu. It accepts one decoded M-extension request from the pipeline with a valid/ready handshake, and prepares operands, including RV64 *W operand extension. It issues a single-cycle start to cpu_mdu and waits for completion. It then presents the formatted result to writeback through a valid/ready handshake, with flush support.

---
 rtl/cpu_mdu_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cpu_mdu_seq.sv
// rtl/cpu_mdu_seq.sv - execute-stage sequencer around cpu_mdu: operand prep, start/wait, writeback handshake, flush
`timescale 1ns/1ps
module cpu_mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic [XLEN-1:0] mdu_operand_a,
    output logic [XLEN-1:0] mdu_operand_b,
    output logic [2:0]      mdu_control,
    output logic            mdu_start,
    input  logic [XLEN-1:0] mdu_result,
    input  logic            mdu_ready,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [2:0]      r_ctrl;
    logic            r_word;
    logic [4:0]      r_rd;
    logic            r_start;
    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_data;

    logic            w_req_ready;
    logic            w_word;
    logic            w_zext;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic [XLEN-1:0] w_res_ext;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_res;

    // Only MUL/DIV/DIVU/REM/REMU have *W forms; MULH* with word set behave as full-width ops.
    assign w_word = (XLEN > 32) && req_word && ((req_funct3 == 3'd0) || req_funct3[2]);
    assign w_zext = req_funct3[2] & req_funct3[0];

    generate
        if (XLEN > 32) begin : g_rv64
            assign w_a_ext   = w_zext ? {{(XLEN-32){1'b0}}, req_rs1[31:0]}
                                      : {{(XLEN-32){req_rs1[31]}}, req_rs1[31:0]};
            assign w_b_ext   = w_zext ? {{(XLEN-32){1'b0}}, req_rs2[31:0]}
                                      : {{(XLEN-32){req_rs2[31]}}, req_rs2[31:0]};
            assign w_res_ext = {{(XLEN-32){mdu_result[31]}}, mdu_result[31:0]};
        end else begin : g_rv32
            assign w_a_ext   = req_rs1;
            assign w_b_ext   = req_rs2;
            assign w_res_ext = mdu_result;
        end
    endgenerate

    assign w_op_a      = w_word ? w_a_ext : req_rs1;
    assign w_op_b      = w_word ? w_b_ext : req_rs2;
    assign w_res       = r_word ? w_res_ext : mdu_result;
    assign w_req_ready = (r_state == S_IDLE) && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_ctrl     <= '0;
            r_word     <= 1'b0;
            r_rd       <= '0;
            r_start    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // rd==0 requests are consumed here and never reach the MDU.
                    if (req_valid && w_req_ready && (req_rd != 5'd0)) begin
                        r_op_a  <= w_op_a;
                        r_op_b  <= w_op_b;
                        r_ctrl  <= req_funct3;
                        r_word  <= w_word;
                        r_rd    <= req_rd;
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (mdu_ready) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_wb_data  <= w_res;
                            r_wb_valid <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mdu_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (wb_ready || flush) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = w_req_ready;
    assign mdu_operand_a = r_op_a;
    assign mdu_operand_b = r_op_b;
    assign mdu_control   = r_ctrl;
    assign mdu_start     = r_start;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_rd;
    assign wb_data       = r_wb_data;
    assign busy          = (r_state != S_IDLE);

endmodule
